// File: rtl/pipe_skid_pkg.sv
// Shared constants for the skid-buffered pipeline stage: state encoding,
// default data width and the state-to-occupancy decode.
package pipe_skid_pkg;

   localparam int DATA_W = 8;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b10;

   // 2'b11 is unreachable but decodes as EMPTY so the stage never wedges.
   function automatic logic [1:0] st_count(input logic [1:0] st);
      case (st)
         ST_BUSY: st_count = 2'd1;
         ST_FULL: st_count = 2'd2;
         default: st_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_if.sv
// Upstream/downstream handshake bundle for pipe_skid.
interface pipe_skid_if #(parameter int width = pipe_skid_pkg::DATA_W) ();

   logic             valid_IN;
   logic [width-1:0] data_IN;
   logic             ready_OUT;
   logic             valid_OUT;
   logic [width-1:0] data_OUT;
   logic             ready_IN;
   logic [1:0]       count_OUT;

   modport master (
      output valid_IN, data_IN, ready_IN,
      input  ready_OUT, valid_OUT, data_OUT, count_OUT
   );

   modport slave (
      input  valid_IN, data_IN, ready_IN,
      output ready_OUT, valid_OUT, data_OUT, count_OUT
   );

endinterface

// File: rtl/pipe_skid_ctl.sv
// Occupancy FSM for the skid stage; emits load enables for the data
// registers that live in the top level.
module pipe_skid_ctl (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_flush,
   input  logic       i_valid,
   input  logic       i_ready,
   output logic       o_ready,
   output logic       o_valid,
   output logic [1:0] o_count,
   output logic       o_ld_main_in,
   output logic       o_ld_main_skid,
   output logic       o_ld_skid,
   output logic       o_clr
);
   import pipe_skid_pkg::*;

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       w_busy, w_full, w_empty;
   logic       w_accept, w_pop;

   assign w_busy  = (r_state == ST_BUSY);
   assign w_full  = (r_state == ST_FULL);
   assign w_empty = ~w_busy & ~w_full;

   // Handshake outputs come only from the state register.
   assign o_ready = ~w_full;
   assign o_valid = ~w_empty;
   assign o_count = st_count(r_state);

   assign w_accept = i_valid & o_ready;
   assign w_pop    = o_valid & i_ready;

   assign o_clr          = i_rst | i_flush;
   assign o_ld_main_in   = ~o_clr & w_accept & (w_empty | (w_busy & w_pop));
   assign o_ld_skid      = ~o_clr & w_accept & w_busy & ~w_pop;
   assign o_ld_main_skid = ~o_clr & w_full & w_pop;

   always_comb begin
      w_next = r_state;
      if (i_flush) begin
         w_next = ST_EMPTY;
      end else if (w_busy) begin
         if (w_accept & ~w_pop)      w_next = ST_FULL;
         else if (~w_accept & w_pop) w_next = ST_EMPTY;
      end else if (w_full) begin
         if (w_pop) w_next = ST_BUSY;
      end else begin
         w_next = w_accept ? ST_BUSY : ST_EMPTY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_EMPTY;
      else       r_state <= w_next;
   end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry skid-buffered pipeline stage: registered ready/valid on both
// sides, strict in-order delivery, synchronous flush.
module pipe_skid #(
   parameter int width = pipe_skid_pkg::DATA_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   pipe_skid_if.slave     bus
);
   import pipe_skid_pkg::*;

   logic [width-1:0] r_main;
   logic [width-1:0] r_skid;
   logic             w_ld_main_in, w_ld_main_skid, w_ld_skid, w_clr;

   pipe_skid_ctl u_ctl (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_flush        (flush),
      .i_valid        (bus.valid_IN),
      .i_ready        (bus.ready_IN),
      .o_ready        (bus.ready_OUT),
      .o_valid        (bus.valid_OUT),
      .o_count        (bus.count_OUT),
      .o_ld_main_in   (w_ld_main_in),
      .o_ld_main_skid (w_ld_main_skid),
      .o_ld_skid      (w_ld_skid),
      .o_clr          (w_clr)
   );

   // Main is the head of the queue; skid only catches the entry that
   // arrives while downstream is stalled.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_main_in)        r_main <= bus.data_IN;
         else if (w_ld_main_skid) r_main <= r_skid;
         if (w_ld_skid)           r_skid <= bus.data_IN;
      end
   end

   assign bus.data_OUT = r_main;

endmodule

// File: doc/pipe_skid.md
PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 SHALL have parameter: width, 8, bit width of the data path.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: flush  input  1  synchronous discard of all held entries.
REQ-005 SHALL have port: valid_IN  input  1  upstream offers data_IN.
REQ-006 SHALL have port: data_IN  input  width  upstream data.
REQ-007 SHALL have port: ready_OUT  output  1  stage can accept this cycle.
REQ-008 SHALL have port: valid_OUT  output  1  data_OUT holds a valid entry.
REQ-009 SHALL have port: data_OUT  output  width  oldest held entry, feeds the downstream register enable/data pair.
REQ-010 SHALL have port: ready_IN  input  1  downstream accepts data_OUT this cycle.
REQ-011 SHALL have port: count_OUT  output  2  number of held entries (0..2).

Function
REQ-012 SHALL define accept = valid_IN & ready_OUT and pop = valid_OUT & ready_IN, both sampled at the rising clk edge.
REQ-013 SHALL implement three states: EMPTY (0 entries), BUSY (main entry only), FULL (main and skid entries).
REQ-014 SHALL drive ready_OUT = (state != FULL), derived only from registered state, with no combinational path from ready_IN or valid_IN.
REQ-015 SHALL drive valid_OUT = (state != EMPTY) and data_OUT = main register, both registered.
REQ-016 EMPTY: on accept, load main <= data_IN and go to BUSY, giving 1-cycle latency from accept to valid_OUT; otherwise hold.
REQ-017 BUSY: on accept & pop, main <= data_IN and stay in BUSY; on accept & ~pop, skid <= data_IN and go to FULL; on ~accept & pop, go to EMPTY; otherwise hold.
REQ-018 FULL: on pop, main <= skid and go to BUSY; otherwise hold both registers.
REQ-019 SHALL preserve order: entries leave in acceptance order, with no loss or duplication under any valid_IN/ready_IN pattern.
REQ-020 SHALL drive count_OUT as 0/1/2 for EMPTY/BUSY/FULL.
REQ-021 flush SHALL force state to EMPTY on the next edge and override accept and pop in that cycle; an entry offered in the flush cycle is dropped.
REQ-022 SHALL clear main and skid to 0 on flush.
REQ-023 SHALL keep data_OUT stable while valid_OUT=1 and ready_IN=0.

Reset
REQ-024 When rst=1 at an edge, SHALL set state EMPTY and main, skid to 0, so that valid_OUT=0, data_OUT=0, count_OUT=0 and ready_OUT=1 after that edge.
REQ-025 rst SHALL take priority over flush, accept and pop, and a reset mid-operation SHALL discard all held entries.
REQ-026 SHALL ignore valid_IN and ready_IN in any cycle with rst=1.

Structure
REQ-027 SHALL take the state encoding from the shared proc package: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10, with 2'b11 decoded as EMPTY.
REQ-028 SHALL take the default data width constant (8) from the same package.
REQ-029 SHALL place the state machine and its enables in one sub-module, pipe_skid_ctl, with the data registers in the top level.

Verification
REQ-030 Reset then single transfer: rst 1 cycle; valid_IN=1, data_IN=8'hA5, ready_IN=1 for 1 cycle -> next cycle valid_OUT=1, data_OUT=8'hA5; following cycle valid_OUT=0.
REQ-031 Backpressure fill: ready_IN=0; offer 8'h11, 8'h22, 8'h33 on consecutive cycles -> 11 and 22 accepted, ready_OUT=0 and count_OUT=2 after the second edge, 33 held upstream.
REQ-032 Drain order: from REQ-031 state, raise ready_IN with 33 still offered -> data_OUT sequence 11, 22, 33, with no gaps after the first pop.
REQ-033 Streaming: valid_IN=ready_IN=1 for 16 cycles with data 0..15 -> outputs 0..15 in order, one per cycle, with count_OUT=1 throughout.
REQ-034 Flush while FULL and offering 8'h44 -> next cycle valid_OUT=0, count_OUT=0, data_OUT=0; 44 is never output.
REQ-035 Reset while FULL with flush=1 -> reset values per REQ-024; a subsequent single transfer behaves as in REQ-030.
